// File: rtl/apb_timer_unit_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL layout and reset values.
package apb_timer_unit_pkg;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h1A10_B000;

  localparam logic [4:0] TIMER_CTRL_OFFS   = 5'h00;
  localparam logic [4:0] TIMER_COUNT_OFFS  = 5'h04;
  localparam logic [4:0] TIMER_CMP_OFFS    = 5'h08;
  localparam logic [4:0] TIMER_STATUS_OFFS = 5'h0C;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_ONESHOT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;

  localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] prescale;
    logic       irq_en;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  // Unused CTRL bits read back as zero.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]      = c.en;
    w[CTRL_ONESHOT_BIT] = c.oneshot;
    w[CTRL_IRQ_EN_BIT]  = c.irq_en;
    w[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = c.prescale;
    return w;
  endfunction

endpackage

// File: rtl/apb_timer_unit_prescaler.sv
// Clock divider for the timer: emits one tick every (divide + 1) enabled cycles.
module timer_prescaler (
  input  logic       clock,
  input  logic       reset_n_sync,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] divide,
  output logic       tick
);

  logic [7:0] pcnt;

  assign tick = en && (pcnt == divide);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n_sync) begin
    if (!reset_n_sync) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/apb_timer_unit.sv
// APB timer: register file, address decode and the count/compare engine driving event and irq.
module apb_timer_unit
  import apb_timer_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset_n_sync,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      event_o,
  output logic                      irq_o
);

  logic [2:0] reg_idx;
  logic       sel_ctrl, sel_count, sel_cmp, sel_status, unmapped;
  logic       access, wr_ctrl, wr_count, wr_cmp, wr_status;
  logic       addr_unused;

  ctrl_t       ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        event_q;
  logic        tick;
  logic        match_hit;
  logic [31:0] rdata;

  assign reg_idx     = PADDR[4:2];
  assign addr_unused = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign sel_ctrl   = (reg_idx == TIMER_CTRL_OFFS[4:2]);
  assign sel_count  = (reg_idx == TIMER_COUNT_OFFS[4:2]);
  assign sel_cmp    = (reg_idx == TIMER_CMP_OFFS[4:2]);
  assign sel_status = (reg_idx == TIMER_STATUS_OFFS[4:2]);
  assign unmapped   = !(sel_ctrl || sel_count || sel_cmp || sel_status);

  assign access    = PSEL && PENABLE;
  assign wr_ctrl   = access && PWRITE && sel_ctrl;
  assign wr_count  = access && PWRITE && sel_count;
  assign wr_cmp    = access && PWRITE && sel_cmp;
  assign wr_status = access && PWRITE && sel_status;

  // Restarting the prescale phase on CTRL or COUNT writes keeps the next period deterministic.
  timer_prescaler u_prescaler (
    .clock        (clock),
    .reset_n_sync (reset_n_sync),
    .en           (ctrl.en),
    .clr          (wr_ctrl || wr_count),
    .divide       (ctrl.prescale),
    .tick         (tick)
  );

  assign match_hit = tick && (count == compare);

  always_ff @(posedge clock or negedge reset_n_sync) begin
    if (!reset_n_sync) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= TIMER_CMP_RESET;
      match   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl.en       <= PWDATA[CTRL_EN_BIT];
        ctrl.oneshot  <= PWDATA[CTRL_ONESHOT_BIT];
        ctrl.irq_en   <= PWDATA[CTRL_IRQ_EN_BIT];
        ctrl.prescale <= PWDATA[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
      end else if (match_hit && ctrl.oneshot) begin
        ctrl.en <= 1'b0;
      end

      // A bus write to COUNT overrides whatever the tick would have produced.
      if (wr_count) begin
        count <= PWDATA;
      end else if (tick) begin
        count <= match_hit ? 32'd0 : count + 32'd1;
      end

      if (wr_cmp) begin
        compare <= PWDATA;
      end

      if (match_hit) begin
        match <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        match <= 1'b0;
      end

      event_q <= match_hit;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (PSEL) begin
      if (sel_ctrl)        rdata = ctrl_to_word(ctrl);
      else if (sel_count)  rdata = count;
      else if (sel_cmp)    rdata = compare;
      else if (sel_status) rdata = {31'd0, match};
    end
  end

  assign PRDATA  = rdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = access && unmapped;
  assign event_o = event_q;
  assign irq_o   = match && ctrl.irq_en;

endmodule

// File: doc/apb_timer_unit.md
# apb_timer_unit

APB responder implementing a 32-bit general-purpose timer with programmable prescaler, compare/auto-reload, and one-shot mode. It occupies the timer slot of the peripheral bus interconnect, responding to APB transfers issued by the AXI-to-APB bridge. It drives a one-cycle event pulse and a level interrupt into the event unit, alongside the UART and GPIO events.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR; only PADDR[4:2] is decoded.
- APB_DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.

- clock  in  1  system clock
- reset_n_sync  in  1  asynchronous, active-low reset
- PADDR  in  APB_ADDR_WIDTH  register address, byte-addressed
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write, 0 = read
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PRDATA  out  32  read data, valid in access phase
- PREADY  out  1  constant 1; zero wait states
- PSLVERR  out  1  error response for an unmapped offset
- event_o  out  1  one-cycle pulse on compare match
- irq_o  out  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN

## Operation
- Register map, word offsets by PADDR[4:2]:
  - 0x00 CTRL: [0] EN, [1] ONESHOT, [2] IRQ_EN, [15:8] PRESCALE; other bits read 0.
  - 0x04 COUNT: RW current count.
  - 0x08 COMPARE: RW match value.
  - 0x0C STATUS: [0] MATCH, sticky; write 1 to clear, write 0 has no effect.
  - 0x10–0x1C are unmapped: PRDATA = 0, PSLVERR = 1, and writes are ignored.
- Access strobe: PSEL & PENABLE. Writes commit at the clock edge ending the access phase. PRDATA is combinational from the registers while PSEL is high, 0 otherwise.
- Prescaler:
  - 8-bit counter pcnt, held at 0 while EN = 0.
  - tick = EN & (pcnt == PRESCALE). On tick pcnt <= 0; otherwise, while EN = 1, pcnt <= pcnt + 1.
- Counter update on tick:
  - If COUNT == COMPARE: COUNT <= 0, MATCH <= 1, event_o <= 1 for one cycle, and if ONESHOT then EN <= 0.
  - Otherwise COUNT <= COUNT + 1, modulo 2^32. If COUNT is above COMPARE it wraps 0xFFFF_FFFF -> 0 without setting MATCH.
- Period: (COMPARE + 1) × (PRESCALE + 1) cycles.
- Simultaneous events:
  - APB write to COUNT in the same cycle as a tick: the written value wins, and pcnt is cleared.
  - Any write to CTRL clears pcnt.
  - STATUS W1C in the same cycle as a match: set wins, MATCH stays 1.
  - Writing EN = 0 in the same cycle as a one-shot match: EN = 0, MATCH = 1.
- Reset values: CTRL = 0, COUNT = 0, COMPARE = 0xFFFF_FFFF, MATCH = 0, pcnt = 0, event_o = 0, irq_o = 0, PREADY = 1, PSLVERR = 0, PRDATA = 0.
- A reset asserted mid-count or mid-transfer returns every register to its reset value immediately. An APB transfer in flight is lost.

## Timing
- PREADY is always 1, so every transfer completes in 2 cycles (setup + access).
- EN written 1 at edge E0 with PRESCALE = 0: COUNT increments at E1, E2, and so on.
- Match edge: the edge at which COUNT == COMPARE and tick are both true. COUNT = 0, MATCH = 1 and event_o = 1 are all visible in the cycle after that edge. event_o returns to 0 one cycle later.
- irq_o is combinational from registered MATCH and IRQ_EN, so it adds no extra latency.
- Writes to COMPARE or PRESCALE take effect for comparisons from the next cycle.

## Structure
- Shared package entries:
  - register offsets TIMER_CTRL_OFFS, TIMER_COUNT_OFFS, TIMER_CMP_OFFS, TIMER_STATUS_OFFS
  - CTRL bit indices
  - COMPARE reset value
  - timer base address for the APB memory map
- Sub-module timer_prescaler: 8-bit pcnt with en, clr and divide inputs; outputs tick.
- Top level holds the APB decode, the register file, and the counter/compare logic.

## Test plan
- Free-running count: PRESCALE = 0, COMPARE = 3, write EN = 1.
  - COUNT reads 0,1,2,3,0; event_o pulses every 4 cycles.
  - MATCH = 1 after the first wrap; irq_o stays 0 while IRQ_EN = 0.
- Prescaled one-shot: PRESCALE = 4, COMPARE = 2, ONESHOT = 1, IRQ_EN = 1.
  - Exactly one event_o pulse, 15 cycles after the enable edge.
  - EN then reads 0 and irq_o = 1.
  - Writing STATUS = 1 drops irq_o the next cycle.
- Collisions:
  - Write COUNT = 0x100 in the same cycle as a tick: COUNT reads 0x100, not the incremented value.
  - W1C on STATUS coinciding with a match: MATCH remains 1.
- Overshoot wrap: COUNT = 0xFFFF_FFFE, COMPARE = 5.
  - COUNT wraps to 0 with no MATCH, then matches at 5.
- Error and reset:
  - Read of offset 0x14 returns PRDATA = 0, PSLVERR = 1; a write there changes nothing.
  - Assert reset_n_sync mid-count: all outputs and registers take their reset values asynchronously.
